// File: rtl/ysyx_24090018_inst_queue.sv
// Instruction queue between fetch (IFU) and decode (IDU).
// Circular FIFO of {pc, inst} pairs with valid/ready on both sides and a
// single-cycle synchronous flush for control-flow redirects.
module ysyx_24090018_inst_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_WIDTH-1:0]      in_pc,
  input  logic [DATA_WIDTH-1:0]      in_inst,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_WIDTH-1:0]      out_pc,
  output logic [DATA_WIDTH-1:0]      out_inst,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  // Storage is intentionally left unreset; only the pointers define validity.
  logic [ADDR_WIDTH-1:0] mem_pc   [DEPTH];
  logic [DATA_WIDTH-1:0] mem_inst [DEPTH];

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [IW-1:0] rd_idx;
  logic [IW-1:0] wr_idx;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;

  assign rd_idx = rd_ptr[IW-1:0];
  assign wr_idx = wr_ptr[IW-1:0];

  // Status, handshakes and head-entry presentation (no bypass from in_*).
  always_comb begin
    empty     = (rd_ptr == wr_ptr);
    full      = (rd_idx == wr_idx) && (rd_ptr[IW] != wr_ptr[IW]);
    count     = wr_ptr - rd_ptr;
    in_ready  = !full;
    out_valid = !empty;
    push      = in_valid && in_ready && !flush;
    pop       = out_valid && out_ready && !flush;
    out_pc    = '0;
    out_inst  = '0;
    if (out_valid) begin
      out_pc   = mem_pc[rd_idx];
      out_inst = mem_inst[rd_idx];
    end
  end

  // Pointer update; flush wins over any push/pop presented in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Entry write at the tail.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_idx]   <= in_pc;
      mem_inst[wr_idx] <= in_inst;
    end
  end

`ifndef SYNTHESIS
  logic                  prev_stall;
  logic [ADDR_WIDTH-1:0] prev_pc;
  logic [DATA_WIDTH-1:0] prev_inst;

  // Remember whether the producer was held off in the previous cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_stall <= 1'b0;
    else        prev_stall <= in_valid && !in_ready && !flush;
  end

  // Capture the stalled payload for the stability check.
  always_ff @(posedge clk) begin
    prev_pc   <= in_pc;
    prev_inst <= in_inst;
  end

  // A stalled producer must keep its payload steady while it stays valid.
  always_ff @(posedge clk) begin
    if (rst_n && prev_stall && in_valid)
      assert (in_pc == prev_pc && in_inst == prev_inst);
  end

  // Occupancy can never exceed the number of entries.
  always_ff @(posedge clk) begin
    if (rst_n) assert (count <= DEPTH_P);
  end
`endif

endmodule

// File: tb/tb_ysyx_24090018_inst_queue.sv
module tb_ysyx_24090018_inst_queue;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] in_pc = '0;
  logic [DW-1:0] in_inst = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_pc;
  logic [DW-1:0] out_inst;
  logic [$clog2(DEPTH):0] count;

  int total = 0;
  int bad   = 0;

  // Reference model: a plain queue of {pc, inst}.
  logic [AW+DW-1:0] mq[$];
  bit last_push, last_pop;

  always #5 clk = ~clk;

  ysyx_24090018_inst_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .count(count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [AW-1:0] epc;
    logic [DW-1:0] einst;
    epc = '0;
    einst = '0;
    if (mq.size() > 0) {epc, einst} = mq[0];
    chk({tag, ".count"},     64'(count),     64'(mq.size()));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(mq.size() > 0));
    chk({tag, ".in_ready"},  64'(in_ready),  64'(mq.size() < DEPTH));
    chk({tag, ".out_pc"},    64'(out_pc),    64'(epc));
    chk({tag, ".out_inst"},  64'(out_inst),  64'(einst));
  endtask

  // One clock with the currently driven inputs; model follows the rules directly.
  task automatic cyc(input string tag);
    last_push = in_valid && (mq.size() < DEPTH) && !flush;
    last_pop  = out_ready && (mq.size() > 0) && !flush;
    @(posedge clk);
    #1;
    if (flush) mq.delete();
    else begin
      if (last_pop)  void'(mq.pop_front());
      if (last_push) mq.push_back({in_pc, in_inst});
    end
    check_all(tag);
  endtask

  logic [AW-1:0] tpc  [4];
  logic [DW-1:0] tins [4];

  initial begin
    int popped;
    int budget;
    tpc[0] = 32'h80000000; tins[0] = 32'h00000413;
    tpc[1] = 32'h80000004; tins[1] = 32'h00100493;
    tpc[2] = 32'h80000008; tins[2] = 32'h00940533;
    tpc[3] = 32'h8000000C; tins[3] = 32'h00100073;

    // Reset then idle
    repeat (3) @(posedge clk);
    #1;
    check_all("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all("reset_rel");
    @(posedge clk);
    #1;
    check_all("idle");

    // Fill
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = tpc[i]; in_inst = tins[i];
      cyc("fill");
    end
    chk("full.count", 64'(count), 64'd4);
    chk("full.in_ready", 64'(in_ready), 64'd0);
    in_pc = 32'h80000010; in_inst = 32'h0000_0013;
    cyc("refuse5th");
    in_valid = 1'b0;
    // Drain in order
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain.pc", 64'(out_pc), 64'(tpc[i]));
      chk("drain.inst", 64'(out_inst), 64'(tins[i]));
      cyc("drain");
    end
    chk("drained.count", 64'(count), 64'd0);
    // Empty boundary: out_ready ignored
    cyc("empty_pop");

    // Concurrent push/pop from empty
    in_valid = 1'b1; out_ready = 1'b1;
    in_pc = 32'h80001000; in_inst = 32'h11111111;
    chk("conc.pre_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 6; i++) begin
      cyc("conc");
      chk("conc.count", 64'(count), 64'd1);
      chk("conc.pc", 64'(out_pc), 64'(32'h80001000 + 32'(4 * i)));
      in_pc = in_pc + 32'd4; in_inst = $urandom;
    end
    in_valid = 1'b0;
    cyc("conc_tail");

    // Wrap-around with random stalls
    popped = 0; budget = 0;
    in_pc = 32'h80002000; in_inst = $urandom;
    while (popped < 20 && budget < 400) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      cyc("wrap");
      if (last_pop) popped++;
      if (last_push) begin in_pc = in_pc + 32'd4; in_inst = $urandom; end
      if (in_pc >= 32'h80002000 + 32'd80) in_valid = 1'b0;
      budget++;
    end
    in_valid = 1'b0;
    chk("wrap.done_in_budget", 64'(popped >= 20), 64'd1);
    out_ready = 1'b1;
    while (mq.size() > 0 && budget < 450) begin cyc("wrap_drain"); budget++; end
    out_ready = 1'b0;

    // Flush with count=3, push and pop both dropped
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = 32'h80000014 + 32'(4 * i); in_inst = $urandom;
      cyc("pre_flush");
    end
    chk("pre_flush.count", 64'(count), 64'd3);
    flush = 1'b1; in_pc = 32'h80000020; in_inst = 32'hdeadbeef; out_ready = 1'b1;
    cyc("flush");
    chk("flush.count", 64'(count), 64'd0);
    chk("flush.out_valid", 64'(out_valid), 64'd0);
    flush = 1'b0; out_ready = 1'b0;
    in_pc = 32'h80000024; in_inst = 32'h00a00513;
    cyc("post_flush");
    chk("post_flush.pc", 64'(out_pc), 64'h80000024);
    in_valid = 1'b0; out_ready = 1'b1;
    cyc("post_flush_pop");
    out_ready = 1'b0;

    // Async reset mid-stream with count=2
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_pc = 32'h80003000 + 32'(4 * i); in_inst = $urandom;
      cyc("pre_rst");
    end
    in_valid = 1'b0;
    chk("pre_rst.count", 64'(count), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    mq.delete();
    chk("async_rst.out_valid", 64'(out_valid), 64'd0);
    chk("async_rst.count", 64'(count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; in_pc = 32'h80004000; in_inst = 32'h00000013;
    cyc("after_rst");
    in_valid = 1'b0;
    cyc("after_rst_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
